// File: rtl/ili9341_frame_source.sv
// Frame pixel generator for the ILI9341 SPI controller: palette-driven patterns
// streamed over a valid/ready interface, redraws scheduled only at frame boundaries.
module ili9341_frame_source #(
    parameter int H_RES      = 240,
    parameter int V_RES      = 320,
    parameter int PIXEL_SIZE = 16,
    parameter int NUM_MODES  = 5,
    parameter int MODE_W     = 3,
    parameter int TILE_SHIFT = 4,
    parameter int BORDER     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [MODE_W-1:0]     mode_in,
    input  logic                  refresh,
    input  logic                  pal_we,
    input  logic [MODE_W-1:0]     pal_addr,
    input  logic [PIXEL_SIZE-1:0] pal_fg,
    input  logic [PIXEL_SIZE-1:0] pal_bg,
    input  logic [1:0]            pal_pat,
    output logic [PIXEL_SIZE-1:0] pix_data,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic                  pix_first,
    output logic                  pix_last,
    output logic                  frame_done,
    output logic                  busy,
    output logic [MODE_W-1:0]     cur_mode
);

    localparam int XW = $clog2(H_RES);
    localparam int YW = $clog2(V_RES);

    typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} state_t;

    state_t                state, state_nx;
    logic [XW-1:0]         x;
    logic [YW-1:0]         y;
    logic [PIXEL_SIZE-1:0] fg_mem  [NUM_MODES];
    logic [PIXEL_SIZE-1:0] bg_mem  [NUM_MODES];
    logic [1:0]            pat_mem [NUM_MODES];
    logic [PIXEL_SIZE-1:0] sh_fg, sh_bg, pixel;
    logic [1:0]            sh_pat;
    logic [MODE_W-1:0]     mode_prev;
    logic                  pending, pend_set, accept, at_last_x, at_last_y;
    logic                  mode_ok, pal_ok, tile_x, tile_y, in_border;

    function automatic logic [PIXEL_SIZE-1:0] default_fg(input int i);
        case (i)
            0:       return PIXEL_SIZE'(16'hFFE0);
            1:       return PIXEL_SIZE'(16'h07FF);
            2:       return PIXEL_SIZE'(16'hF800);
            3:       return PIXEL_SIZE'(16'h780F);
            4:       return PIXEL_SIZE'(16'h0000);
            default: return PIXEL_SIZE'(16'h001F);
        endcase
    endfunction

    // Handshake: a pixel transfers on a rising edge where pix_valid && pix_ready;
    // while pix_valid is high and pix_ready low, data and markers hold stable.
    assign accept    = pix_valid && pix_ready;
    assign at_last_x = (x == XW'(H_RES - 1));
    assign at_last_y = (y == YW'(V_RES - 1));
    assign mode_ok   = (32'(mode_in) < NUM_MODES);
    assign pal_ok    = (32'(pal_addr) < NUM_MODES);
    assign pend_set  = (mode_in != mode_prev) || refresh;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_MODES; i++) begin
                fg_mem[i]  <= default_fg(i);
                bg_mem[i]  <= '0;
                pat_mem[i] <= '0;
            end
        end else if (pal_we && pal_ok) begin
            fg_mem[pal_addr]  <= pal_fg;
            bg_mem[pal_addr]  <= pal_bg;
            pat_mem[pal_addr] <= pal_pat;
        end
    end

    // Unreset on purpose: it keeps tracking mode_in through reset, so releasing
    // reset does not look like a mode change and schedule a second frame.
    always_ff @(posedge clk) begin
        mode_prev <= mode_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pending <= 1'b1;
        end else begin
            state <= state_nx;
            if (pend_set) begin
                pending <= 1'b1;
            end else if (state == IDLE && pending) begin
                pending <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (pending) state_nx = LOAD;
            LOAD:    state_nx = STREAM;
            STREAM:  if (accept && at_last_x && at_last_y) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x        <= '0;
            y        <= '0;
            cur_mode <= '0;
            sh_fg    <= '0;
            sh_bg    <= '0;
            sh_pat   <= '0;
        end else if (state == LOAD) begin
            cur_mode <= mode_in;
            x        <= '0;
            y        <= '0;
            if (mode_ok) begin
                sh_fg  <= fg_mem[mode_in];
                sh_bg  <= bg_mem[mode_in];
                sh_pat <= pat_mem[mode_in];
            end else begin
                sh_fg  <= PIXEL_SIZE'(16'h001F);
                sh_bg  <= '0;
                sh_pat <= 2'd0;
            end
        end else if (accept) begin
            if (at_last_x) begin
                x <= '0;
                y <= at_last_y ? '0 : y + YW'(1);
            end else begin
                x <= x + XW'(1);
            end
        end
    end

    assign tile_x    = 1'(x >> TILE_SHIFT);
    assign tile_y    = 1'(y >> TILE_SHIFT);
    assign in_border = (x < XW'(BORDER)) || (x >= XW'(H_RES - BORDER)) ||
                       (y < YW'(BORDER)) || (y >= YW'(V_RES - BORDER));

    always_comb begin
        pixel = sh_fg;
        case (sh_pat)
            2'd1:    if (tile_x ^ tile_y) pixel = sh_bg;
            2'd2:    if (!in_border) pixel = sh_bg;
            2'd3:    if (tile_y) pixel = sh_bg;
            default: pixel = sh_fg;
        endcase
    end

    assign pix_valid  = (state == STREAM);
    assign pix_data   = pix_valid ? pixel : '0;
    assign pix_first  = pix_valid && (x == '0) && (y == '0);
    assign pix_last   = pix_valid && at_last_x && at_last_y;
    assign frame_done = (state == DONE);
    assign busy       = (state == LOAD) || (state == STREAM);

endmodule
